// File: rtl/vga_pkg.sv
// ============================================================================
// Module  : vga_pkg
// Purpose : Default 640x480@60 timing constants and the coordinate type.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FRONT  = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BACK   = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FRONT  = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BACK   = 33;

  localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  typedef logic [9:0] coord_t;

endpackage

`default_nettype wire

// File: rtl/pix_tick_gen.sv
// ============================================================================
// Module  : pix_tick_gen
// Purpose : CLK_DIV prescaler; registered one-clk pix_tick per pixel period.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pix_tick_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset_n,
  output logic pix_tick
);

  logic r_tick;

  generate
    if (CLK_DIV == 1) begin : g_div1
      // Every clk is a pixel clk; only the reset cycle is tick-free.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_tick <= 1'b0;
        else          r_tick <= 1'b1;
      end
    end else begin : g_divn
      localparam int c_W = $clog2(CLK_DIV);
      localparam logic [c_W-1:0] c_LAST = c_W'(CLK_DIV - 1);

      logic [c_W-1:0] r_cnt;
      logic [c_W-1:0] w_cnt_nxt;

      always_comb begin
        w_cnt_nxt = r_cnt + c_W'(1);
        if (r_cnt == c_LAST) w_cnt_nxt = '0;
      end

      // Tick is decoded from the next count so it aligns with r_cnt == c_LAST.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_cnt  <= '0;
          r_tick <= 1'b0;
        end else begin
          r_cnt  <= w_cnt_nxt;
          r_tick <= (w_cnt_nxt == c_LAST);
        end
      end
    end
  endgenerate

  assign pix_tick = r_tick;

endmodule

`default_nettype wire

// File: rtl/vga_timer.sv
// ============================================================================
// Module  : vga_timer
// Purpose : VGA x/y counters with registered sync and active-video decode.
//           Option VGA_TIMER_SYNC_DELAY_EN delays sync/blank by one clk.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_timer
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE    = vga_pkg::H_ACTIVE,
  parameter int   H_FRONT     = vga_pkg::H_FRONT,
  parameter int   H_SYNC      = vga_pkg::H_SYNC,
  parameter int   H_BACK      = vga_pkg::H_BACK,
  parameter int   V_ACTIVE    = vga_pkg::V_ACTIVE,
  parameter int   V_FRONT     = vga_pkg::V_FRONT,
  parameter int   V_SYNC      = vga_pkg::V_SYNC,
  parameter int   V_BACK      = vga_pkg::V_BACK,
  parameter int   CLK_DIV     = 2,
  parameter logic SYNC_ACTIVE = 1'b0
) (
  input  logic   clk,
  input  logic   reset_n,
  output logic   pix_tick,
  output coord_t x,
  output coord_t y,
  output logic   activevideo,
  output logic   hsync,
  output logic   vsync,
  output logic   frame_start
);

  localparam int c_H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int c_V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int c_HW      = $clog2(c_H_TOTAL);
  localparam int c_VW      = $clog2(c_V_TOTAL);

  localparam logic [c_HW-1:0] c_H_LAST = c_HW'(c_H_TOTAL - 1);
  localparam logic [c_VW-1:0] c_V_LAST = c_VW'(c_V_TOTAL - 1);

  // Decode bounds carry one spare bit so an end bound equal to the total fits.
  localparam logic [c_HW:0] c_H_ACT  = (c_HW+1)'(H_ACTIVE);
  localparam logic [c_HW:0] c_HS_BEG = (c_HW+1)'(H_ACTIVE + H_FRONT);
  localparam logic [c_HW:0] c_HS_END = (c_HW+1)'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [c_VW:0] c_V_ACT  = (c_VW+1)'(V_ACTIVE);
  localparam logic [c_VW:0] c_VS_BEG = (c_VW+1)'(V_ACTIVE + V_FRONT);
  localparam logic [c_VW:0] c_VS_END = (c_VW+1)'(V_ACTIVE + V_FRONT + V_SYNC);

  logic            w_tick;
  logic [c_HW-1:0] r_x, w_x_nxt;
  logic [c_VW-1:0] r_y, w_y_nxt;
  logic            w_wrap;
  logic            w_hs_on, w_vs_on, w_act;
  logic            r_hs, r_vs, r_act, r_fs;

  pix_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_pix_tick_gen (
    .clk      (clk),
    .reset_n  (reset_n),
    .pix_tick (w_tick)
  );

  always_comb begin
    w_x_nxt = r_x;
    w_y_nxt = r_y;
    w_wrap  = 1'b0;
    if (w_tick) begin
      if (r_x == c_H_LAST) begin
        w_x_nxt = '0;
        if (r_y == c_V_LAST) begin
          w_y_nxt = '0;
          w_wrap  = 1'b1;
        end else begin
          w_y_nxt = r_y + c_VW'(1);
        end
      end else begin
        w_x_nxt = r_x + c_HW'(1);
      end
    end
  end

  // Decode from next-state counters so registered outputs match the new x/y.
  always_comb begin
    w_hs_on = ({1'b0, w_x_nxt} >= c_HS_BEG) && ({1'b0, w_x_nxt} < c_HS_END);
    w_vs_on = ({1'b0, w_y_nxt} >= c_VS_BEG) && ({1'b0, w_y_nxt} < c_VS_END);
    w_act   = ({1'b0, w_x_nxt} < c_H_ACT)   && ({1'b0, w_y_nxt} < c_V_ACT);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_x   <= '0;
      r_y   <= '0;
      r_hs  <= ~SYNC_ACTIVE;
      r_vs  <= ~SYNC_ACTIVE;
      r_act <= 1'b1;
      r_fs  <= 1'b0;
    end else begin
      r_x   <= w_x_nxt;
      r_y   <= w_y_nxt;
      r_hs  <= w_hs_on ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      r_vs  <= w_vs_on ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      r_act <= w_act;
      r_fs  <= w_wrap;
    end
  end

  assign pix_tick    = w_tick;
  assign x           = coord_t'(r_x);
  assign y           = coord_t'(r_y);
  assign frame_start = r_fs;

`ifdef VGA_TIMER_SYNC_DELAY_EN
  // Lags sync/blank by one clk to match the bitmap memory read latency.
  logic r_hs_d, r_vs_d, r_act_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hs_d  <= ~SYNC_ACTIVE;
      r_vs_d  <= ~SYNC_ACTIVE;
      r_act_d <= 1'b1;
    end else begin
      r_hs_d  <= r_hs;
      r_vs_d  <= r_vs;
      r_act_d <= r_act;
    end
  end

  assign hsync       = r_hs_d;
  assign vsync       = r_vs_d;
  assign activevideo = r_act_d;
`else
  assign hsync       = r_hs;
  assign vsync       = r_vs;
  assign activevideo = r_act;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vga_timer.sv
// ============================================================================
// Module  : tb_vga_timer
// Purpose : Directed self-checking bench: full-size line timing, reduced-size
//           frame timing, mid-frame reset and CLK_DIV=1.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_timer;
  import vga_pkg::*;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic rst_a, rst_b, rst_c;

  logic   a_tick, a_act, a_hs, a_vs, a_fs;
  coord_t a_x, a_y;
  logic   b_tick, b_act, b_hs, b_vs, b_fs;
  coord_t b_x, b_y;
  logic   c_tick, c_act, c_hs, c_vs, c_fs;
  coord_t c_x, c_y;

  int n_assert = 0;
  int n_fail   = 0;

`ifdef VGA_TIMER_SYNC_DELAY_EN
  localparam int c_SYNC_LAG = 1;
`else
  localparam int c_SYNC_LAG = 0;
`endif

  // Full 640x480 timing, CLK_DIV=2
  vga_timer u_dut_a (
    .clk(clk), .reset_n(rst_a), .pix_tick(a_tick), .x(a_x), .y(a_y),
    .activevideo(a_act), .hsync(a_hs), .vsync(a_vs), .frame_start(a_fs)
  );

  // Reduced timing: H_TOTAL=32, V_TOTAL=15, CLK_DIV=2 -> frame = 960 clk
  vga_timer #(
    .H_ACTIVE(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(6),
    .V_ACTIVE(8),  .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
    .CLK_DIV(2),   .SYNC_ACTIVE(1'b0)
  ) u_dut_b (
    .clk(clk), .reset_n(rst_b), .pix_tick(b_tick), .x(b_x), .y(b_y),
    .activevideo(b_act), .hsync(b_hs), .vsync(b_vs), .frame_start(b_fs)
  );

  // Same reduced timing with CLK_DIV=1 -> frame = 480 clk
  vga_timer #(
    .H_ACTIVE(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(6),
    .V_ACTIVE(8),  .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
    .CLK_DIV(1),   .SYNC_ACTIVE(1'b0)
  ) u_dut_c (
    .clk(clk), .reset_n(rst_c), .pix_tick(c_tick), .x(c_x), .y(c_y),
    .activevideo(c_act), .hsync(c_hs), .vsync(c_vs), .frame_start(c_fs)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    int first656, first_hs_low, hs_low, act_low, x_last;
    int fs1, fs2, fs_cnt, vs_low, act_bad, found;
    int c_fs1, c_fs2, c_tick0, c_line_n;

    rst_a = 1'b0;
    rst_b = 1'b0;
    rst_c = 1'b0;
    repeat (3) @(negedge clk);

    // ---------------- reset state ----------------
    check("rst_x",     a_x,    0);
    check("rst_y",     a_y,    0);
    check("rst_tick",  a_tick, 0);
    check("rst_fs",    a_fs,   0);
    check("rst_act",   a_act,  1);
    check("rst_hsync", a_hs,   1);
    check("rst_vsync", a_vs,   1);

    // ---------------- post-reset sequence, full timing ----------------
    rst_a = 1'b1;
    @(negedge clk);
    check("a_e1_tick", a_tick, 1);
    check("a_e1_x",    a_x,    0);
    @(negedge clk);
    check("a_e2_tick", a_tick, 0);
    check("a_e2_x",    a_x,    1);
    @(negedge clk);
    check("a_e3_tick", a_tick, 1);
    check("a_e3_x",    a_x,    1);
    check("a_e3_hs",   a_hs,   1);
    check("a_e3_vs",   a_vs,   1);
    check("a_e3_act",  a_act,  1);
    @(negedge clk);
    check("a_e4_x",    a_x,    2);

    first656 = -1; first_hs_low = -1; hs_low = 0; act_low = 0; x_last = -1;
    for (int n = 5; n <= 1600; n++) begin
      @(negedge clk);
      if (a_x == 656 && first656 < 0) first656 = n;
      if (!a_hs) begin
        hs_low++;
        if (first_hs_low < 0) first_hs_low = n;
      end
      if (!a_act) act_low++;
      if (n == 1599) x_last = a_x;
    end
    check("a_x656_cycle",  first656,     1312);
    check("a_hs_fall",     first_hs_low, 1312 + c_SYNC_LAG);
    check("a_hs_low_clk",  hs_low,       192);
    check("a_act_low_clk", act_low,      320);
    check("a_x_before_wrap", x_last,     799);
    check("a_line_wrap_x", a_x,          0);
    check("a_line_wrap_y", a_y,          1);
    check("a_vs_line1",    a_vs,         1);

    // ---------------- frame timing, reduced size ----------------
    rst_b = 1'b1;
    fs1 = -1; fs2 = -1; fs_cnt = 0; vs_low = 0; act_bad = 0;
    for (int n = 1; n <= 1925; n++) begin
      @(negedge clk);
      if (b_fs) begin
        fs_cnt++;
        if (fs1 < 0) fs1 = n;
        else if (fs2 < 0) fs2 = n;
      end
      if (fs1 > 0 && n > fs1 && n <= fs1 + 960 && !b_vs) vs_low++;
      if (b_y >= 8 && b_act) act_bad++;
    end
    check("b_fs_first",   fs1,       960);
    check("b_fs_period",  fs2 - fs1, 960);
    check("b_fs_pulses",  fs_cnt,    2);
    check("b_vs_low_clk", vs_low,    128);
    check("b_act_blank",  act_bad,   0);

    // ---------------- mid-frame asynchronous reset ----------------
    found = 0;
    for (int k = 0; k < 1000 && found == 0; k++) begin
      @(negedge clk);
      if (b_x == 20 && b_y == 5) found = 1;
    end
    check("b_reach_mid", found, 1);
    #2 rst_b = 1'b0;
    #1;
    check("b_arst_x",    b_x,    0);
    check("b_arst_y",    b_y,    0);
    check("b_arst_hs",   b_hs,   1);
    check("b_arst_vs",   b_vs,   1);
    check("b_arst_act",  b_act,  1);
    check("b_arst_tick", b_tick, 0);
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    check("b_r1_tick", b_tick, 1);
    check("b_r1_x",    b_x,    0);
    check("b_r1_fs",   b_fs,   0);
    @(negedge clk);
    check("b_r2_tick", b_tick, 0);
    check("b_r2_x",    b_x,    1);
    @(negedge clk);
    check("b_r3_tick", b_tick, 1);
    check("b_r3_x",    b_x,    1);

    // ---------------- CLK_DIV = 1 ----------------
    rst_c = 1'b1;
    c_fs1 = -1; c_fs2 = -1; c_tick0 = 0; c_line_n = -1;
    for (int n = 1; n <= 1000; n++) begin
      @(negedge clk);
      if (!c_tick) c_tick0++;
      if (c_y == 1 && c_line_n < 0) c_line_n = n;
      if (c_fs) begin
        if (c_fs1 < 0) c_fs1 = n;
        else if (c_fs2 < 0) c_fs2 = n;
      end
    end
    check("c_tick_zero_clk", c_tick0,       0);
    check("c_line_clk",      c_line_n,      33);
    check("c_fs_first",      c_fs1,         481);
    check("c_fs_period",     c_fs2 - c_fs1, 480);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
